// File: rtl/pwm_axi_lite_slave.sv
// AXI4-Lite register file (CTRL/PERIOD/DUTY/SCRATCH) driving a single PWM output.
// Write address and data are captured independently; the register update is
// taken in the same cycle the second half arrives, so BVALID follows one cycle later.
module pwm_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            pwm_out
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    // write channel state
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [1:0]    wsel_q, wsel_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [NB-1:0] wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    // read channel state
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    // register file
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];
    // PWM engine
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   sper_q, sper_d;
    logic [31:0]   sduty_q, sduty_d;
    logic          en_q, en_d;
    logic          pwm_q, pwm_d;

    logic          aw_hs, w_hs, wr_fire, ar_hs;
    logic [1:0]    wsel;
    logic [DW-1:0] wdata_eff;
    logic [NB-1:0] wstrb_eff;
    logic          en, pol, active;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // a half of the write is "present" if it is held or handshaking right now
    assign aw_hs     = S_AXI_AWVALID & awready_q;
    assign w_hs      = S_AXI_WVALID & wready_q;
    assign wsel      = aw_held_q ? wsel_q  : S_AXI_AWADDR[3:2];
    assign wdata_eff = w_held_q  ? wdata_q : S_AXI_WDATA;
    assign wstrb_eff = w_held_q  ? wstrb_q : S_AXI_WSTRB;
    assign wr_fire   = (aw_held_q | aw_hs) & (w_held_q | w_hs) & (~bvalid_q | S_AXI_BREADY);
    assign ar_hs     = S_AXI_ARVALID & arready_q;

    // write channel: capture halves, fire the write, manage BVALID and READY pulses
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        wsel_d    = wsel_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (aw_hs && !wr_fire) begin
            aw_held_d = 1'b1;
            wsel_d    = S_AXI_AWADDR[3:2];
        end
        if (w_hs && !wr_fire) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (wr_fire)
            bvalid_d = 1'b1;
        else if (S_AXI_BREADY)
            bvalid_d = 1'b0;
        else
            bvalid_d = bvalid_q;
        // READY is a single-cycle pulse, withheld while a response is stalled
        awready_d = S_AXI_AWVALID & ~aw_held_d & ~awready_q & ~bvalid_d;
        wready_d  = S_AXI_WVALID  & ~w_held_d  & ~wready_q  & ~bvalid_d;
    end

    // register file byte-lane update
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            regs_d[r] = regs_q[r];
            for (int b = 0; b < NB; b++) begin
                if (wr_fire && wsel == 2'(r) && wstrb_eff[b])
                    regs_d[r][8*b +: 8] = wdata_eff[8*b +: 8];
            end
        end
    end

    // read channel: sample the register at the AR handshake, hold until RREADY
    always_comb begin
        rdata_d = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_d;
    end

    // PWM counter and shadow reload; shadows only change at period boundaries
    always_comb begin
        en      = regs_q[0][0];
        pol     = regs_q[0][1];
        en_d    = en;
        cnt_d   = cnt_q;
        sper_d  = sper_q;
        sduty_d = sduty_q;
        if (!en) begin
            cnt_d = '0;
        end else if (!en_q || sper_q == '0 || cnt_q >= sper_q - 32'd1) begin
            cnt_d   = '0;
            sper_d  = regs_q[1];
            sduty_d = regs_q[2];
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        // first enabled cycle still has stale shadows, so it stays inactive
        active = en & en_q & (sper_q != '0) & (cnt_q < sduty_q);
        pwm_d  = active ^ pol;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wsel_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int r = 0; r < 4; r++) regs_q[r] <= '0;
            cnt_q     <= '0;
            sper_q    <= '0;
            sduty_q   <= '0;
            en_q      <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            wsel_q    <= wsel_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int r = 0; r < 4; r++) regs_q[r] <= regs_d[r];
            cnt_q     <= cnt_d;
            sper_q    <= sper_d;
            sduty_q   <= sduty_d;
            en_q      <= en_d;
            pwm_q     <= pwm_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign pwm_out       = pwm_q;
endmodule

// File: tb/tb_pwm_axi_lite_slave.sv
// Directed bench for pwm_axi_lite_slave: AXI writes/reads, strobes, channel skew,
// response backpressure, PWM waveform shapes and reset abort.
module tb_pwm_axi_lite_slave;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        pwm_out;

    int ncmp = 0;
    int nerr = 0;
    logic hist [0:63];
    int   hn = 0;
    bit   rec = 0;

    pwm_axi_lite_slave dut (
        .ACLK(clk), .ARESETN(arstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge, optionally logging pwm_out
    task automatic tick();
        @(negedge clk);
        if (rec && hn < 64) begin
            hist[hn] = pwm_out;
            hn++;
        end
    endtask

    function automatic int run_len(input int s);
        int n = 0;
        while (s + n < hn && hist[s+n] === hist[s]) n++;
        return n;
    endfunction

    // b_hold < 0: leave the response pending and return
    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_hold);
        bit aw_ok = 0;
        bit w_ok = 0;
        int c = 0;
        awaddr = a; wdata = d; wstrb = s; bready = (b_hold == 0);
        while (!(aw_ok && w_ok) && c < 30) begin
            awvalid = !aw_ok && c >= aw_dly;
            wvalid  = !w_ok && c >= w_dly;
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            tick();
            c++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", {31'd0, aw_ok & w_ok}, 32'd1);
        c = 0;
        while (bvalid !== 1'b1 && c < 10) begin tick(); c++; end
        chk("bvalid_rise", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, 32'd0);
        if (b_hold >= 0) begin
            for (int i = 0; i < b_hold; i++) begin
                awvalid = 1; awaddr = 4'h8;
                chk("no_awready_stall", {31'd0, awready}, 32'd0);
                chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
                tick();
            end
            awvalid = 0; awaddr = a;
            bready = 1;
            tick();
            chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
            bready = 0;
        end
    endtask

    task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
        bit ok = 0;
        int c = 0;
        araddr = a; rready = 1; arvalid = 1;
        while (!ok && c < 20) begin
            if (arready) ok = 1;
            tick();
            c++;
        end
        arvalid = 0;
        chk("rd_handshake", {31'd0, ok}, 32'd1);
        c = 0;
        while (rvalid !== 1'b1 && c < 10) begin tick(); c++; end
        chk("rvalid_rise", {31'd0, rvalid}, 32'd1);
        chk("rresp", {30'd0, rresp}, 32'd0);
        d = rdata;
        tick();
        rready = 0;
    endtask

    // find a rising edge, then measure the high run and the following low run
    task automatic meas(output int hi, output int lo);
        bit prev;
        bit found = 0;
        int g = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = pwm_out;
            tick();
            if (!prev && pwm_out) found = 1;
        end
        chk("pwm_edge_found", {31'd0, found}, 32'd1);
        hi = 0; lo = 0;
        while (pwm_out === 1'b1 && g < 40) begin hi++; tick(); g++; end
        while (pwm_out === 1'b0 && g < 80) begin lo++; tick(); g++; end
    endtask

    initial begin
        logic [31:0] rd;
        int hi, lo, ones, s;

        repeat (2) tick();
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        chk("rst_pwm",     {31'd0, pwm_out}, 32'd0);
        arstn = 1;
        tick();

        // basic writes then read back
        axi_wr(4'h0, 32'd1, 4'hF, 0, 0, 0);
        chk("pwm_low_w0", {31'd0, pwm_out}, 32'd0);
        axi_wr(4'h4, 32'd2, 4'hF, 0, 0, 0);
        chk("pwm_low_w1", {31'd0, pwm_out}, 32'd0);
        axi_wr(4'h8, 32'd3, 4'hF, 0, 0, 0);
        axi_wr(4'hC, 32'd4, 4'hF, 0, 0, 0);
        axi_rd(4'h0, rd); chk("rd_reg0", rd, 32'd1);
        axi_rd(4'h4, rd); chk("rd_reg1", rd, 32'd2);
        axi_rd(4'h8, rd); chk("rd_reg2", rd, 32'd3);
        axi_rd(4'hC, rd); chk("rd_reg3", rd, 32'd4);

        // byte strobes
        axi_wr(4'hC, 32'd0, 4'hF, 0, 0, 0);
        axi_wr(4'hC, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        axi_rd(4'hC, rd); chk("rd_strobe", rd, 32'h00BB00DD);

        // AW leads W with stalled response, then W leads AW
        axi_wr(4'hC, 32'h55, 4'hF, 0, 3, 5);
        axi_rd(4'hC, rd); chk("rd_aw_first", rd, 32'h55);
        axi_rd(4'h8, rd); chk("rd_no_stray_write", rd, 32'd3);
        axi_wr(4'hC, 32'h66, 4'hF, 3, 0, 0);
        axi_rd(4'hC, rd); chk("rd_w_first", rd, 32'h66);

        // PWM 3 high / 7 low, then inverted
        axi_wr(4'h4, 32'd10, 4'hF, 0, 0, 0);
        axi_wr(4'h8, 32'd3, 4'hF, 0, 0, 0);
        axi_wr(4'h0, 32'd1, 4'hF, 0, 0, 0);
        repeat (12) tick();
        meas(hi, lo);
        chk("pwm_hi", hi, 32'd3);
        chk("pwm_lo", lo, 32'd7);
        axi_wr(4'h0, 32'd3, 4'hF, 0, 0, 0);
        repeat (12) tick();
        meas(hi, lo);
        chk("pwm_inv_hi", hi, 32'd7);
        chk("pwm_inv_lo", lo, 32'd3);
        axi_wr(4'h0, 32'd1, 4'hF, 0, 0, 0);
        repeat (12) tick();

        // DUTY changed early in a period takes effect on the next period
        s = 0;
        for (int i = 0; i < 40; i++) begin
            logic p;
            p = pwm_out;
            tick();
            if (!p && pwm_out) begin s = 1; break; end
        end
        chk("duty_edge_found", s, 32'd1);
        hist[0] = pwm_out; hn = 1; rec = 1;
        axi_wr(4'h8, 32'd8, 4'hF, 0, 0, 0);
        repeat (25) tick();
        rec = 0;
        s = 0;
        hi = run_len(s); chk("duty_cur_hi", hi, 32'd3);  s += hi;
        lo = run_len(s); chk("duty_cur_lo", lo, 32'd7);  s += lo;
        hi = run_len(s); chk("duty_next_hi", hi, 32'd8); s += hi;
        lo = run_len(s); chk("duty_next_lo", lo, 32'd2);

        // duty >= period: always active
        axi_wr(4'h8, 32'd12, 4'hF, 0, 0, 0);
        repeat (15) tick();
        ones = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (pwm_out === 1'b1) ones++; end
        chk("duty_full", ones, 32'd20);

        // period 0: always inactive
        axi_wr(4'h4, 32'd0, 4'hF, 0, 0, 0);
        repeat (15) tick();
        ones = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (pwm_out === 1'b1) ones++; end
        chk("period_zero", ones, 32'd0);

        // reset while a response is pending and PWM is running
        axi_wr(4'h4, 32'd10, 4'hF, 0, 0, 0);
        axi_wr(4'h8, 32'd3, 4'hF, 0, 0, 0);
        repeat (12) tick();
        axi_wr(4'hC, 32'h77, 4'hF, 0, 0, -1);
        arstn = 0;
        tick();
        chk("rst2_awready", {31'd0, awready}, 32'd0);
        chk("rst2_wready",  {31'd0, wready},  32'd0);
        chk("rst2_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst2_arready", {31'd0, arready}, 32'd0);
        chk("rst2_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst2_rdata",   rdata,            32'd0);
        chk("rst2_pwm",     {31'd0, pwm_out}, 32'd0);
        arstn = 1;
        bready = 1;
        tick();
        chk("rst2_no_bresp", {31'd0, bvalid}, 32'd0);
        bready = 0;
        axi_rd(4'h0, rd); chk("rst2_reg0", rd, 32'd0);
        axi_rd(4'h4, rd); chk("rst2_reg1", rd, 32'd0);
        axi_rd(4'h8, rd); chk("rst2_reg2", rd, 32'd0);
        axi_rd(4'hC, rd); chk("rst2_reg3", rd, 32'd0);
        chk("rst2_pwm_after", {31'd0, pwm_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
